// File: rtl/brick_collision_scan_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : brick_collision_scan_if                                      |
// | Description : Scan request/response bundle between ball controller and the |
// |               brick collision scanner.                                     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface brick_collision_scan_if;
  logic       start;
  logic [7:0] x;
  logic [6:0] y;
  logic       h_dir;
  logic       v_dir;
  logic       busy;
  logic       done;
  logic [1:0] v_col_count;
  logic [1:0] h_col_count;
  logic [1:0] d_col_count;

  modport master (
    output start, x, y, h_dir, v_dir,
    input  busy, done, v_col_count, h_col_count, d_col_count
  );

  modport slave (
    input  start, x, y, h_dir, v_dir,
    output busy, done, v_col_count, h_col_count, d_col_count
  );
endinterface
`default_nettype wire

// File: rtl/brick_collision_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : brick_collision_scan                                         |
// | Description : Brick alive bitmap owner; probes the 7 pixels ahead of the   |
// |               3x3 ball, counts v/h/d hits and clears the bricks it hit.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module brick_collision_scan #(
  parameter int COLS         = 10,
  parameter int ROWS         = 5,
  parameter int BRICK_W_LOG2 = 4,
  parameter int BRICK_H_LOG2 = 2,
  parameter int BRICK_Y0     = 16
) (
  input  logic                  clock,
  input  logic                  reset_state,
  brick_collision_scan_if.slave scan,
  input  logic                  level_load,
  output logic [5:0]            bricks_left,
  output logic                  all_cleared,
  input  logic [3:0]            rd_col,
  input  logic [2:0]            rd_row,
  output logic                  rd_alive
);

  localparam int c_total = COLS * ROWS;
  localparam int c_iw    = $clog2(c_total);
  localparam logic signed [8:0] c_px_max = 9'(COLS << BRICK_W_LOG2);
  localparam logic signed [8:0] c_py_min = 9'(BRICK_Y0);
  localparam logic signed [8:0] c_py_max = 9'(BRICK_Y0 + (ROWS << BRICK_H_LOG2));
  localparam logic [8:0]         c_cols9  = 9'(COLS);
  localparam logic [c_total-1:0] c_all    = '1;
  localparam logic [c_total-1:0] c_one    = c_total'(1);
  localparam logic [5:0]         c_full   = 6'(c_total);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [7:0]         r_x;
  logic [6:0]         r_y;
  logic               r_h_dir;
  logic               r_v_dir;
  logic [2:0]         r_idx;
  logic [c_total-1:0] r_alive;
  logic [c_total-1:0] r_hit_mask;
  logic [2:0]         r_distinct;
  logic [5:0]         r_bricks_left;
  logic [1:0]         r_v_cnt;
  logic [1:0]         r_h_cnt;
  logic [1:0]         r_d_cnt;

  logic signed [8:0]  w_x_s;
  logic signed [8:0]  w_y_s;
  logic signed [8:0]  w_yv;
  logic signed [8:0]  w_xh;
  logic signed [8:0]  w_px;
  logic signed [8:0]  w_py;
  logic signed [8:0]  w_dy;
  logic [8:0]         w_col;
  logic [8:0]         w_row;
  logic [c_iw-1:0]    w_bit_idx;
  logic [c_iw-1:0]    w_rd_idx;
  logic               w_in_field;
  logic               w_hit;
  logic               w_first_hit;
  logic               w_is_v;
  logic               w_is_h;
  logic               w_is_d;

  // Probe geometry: one pixel beyond the ball edge in each direction of travel.
  assign w_x_s = $signed({1'b0, r_x});
  assign w_y_s = $signed({2'b00, r_y});
  assign w_yv  = r_v_dir ? w_y_s + 9'sd3 : w_y_s - 9'sd1;
  assign w_xh  = r_h_dir ? w_x_s + 9'sd3 : w_x_s - 9'sd1;

  always_comb begin
    w_px = w_xh;
    w_py = w_yv;
    case (r_idx)
      3'd0:    w_px = w_x_s;
      3'd1:    w_px = w_x_s + 9'sd1;
      3'd2:    w_px = w_x_s + 9'sd2;
      3'd3:    w_py = w_y_s;
      3'd4:    w_py = w_y_s + 9'sd1;
      3'd5:    w_py = w_y_s + 9'sd2;
      default: ;
    endcase
  end

  assign w_in_field  = (w_px >= 9'sd0) && (w_px < c_px_max) &&
                       (w_py >= c_py_min) && (w_py < c_py_max);
  assign w_dy        = w_py - c_py_min;
  assign w_col       = $unsigned(w_px) >> BRICK_W_LOG2;
  assign w_row       = $unsigned(w_dy) >> BRICK_H_LOG2;
  assign w_bit_idx   = c_iw'(w_row * c_cols9 + w_col);
  assign w_hit       = (r_state == S_PROBE) && w_in_field && (w_col < c_cols9) &&
                       r_alive[w_bit_idx];
  assign w_first_hit = w_hit && !r_hit_mask[w_bit_idx];

  assign w_is_v = (r_idx < 3'd3);
  assign w_is_d = (r_idx == 3'd6);
  assign w_is_h = !w_is_v && !w_is_d;

  assign w_rd_idx = c_iw'(7'(rd_row) * 7'(COLS) + 7'(rd_col));
  assign rd_alive = ({1'b0, rd_col} < 5'(COLS)) && ({1'b0, rd_row} < 4'(ROWS)) &&
                    r_alive[w_rd_idx];

  always_ff @(posedge clock or negedge reset_state) begin
    if (!reset_state) r_state <= S_IDLE;
    else              r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (scan.start) w_state_next = S_PROBE;
      S_PROBE: if (r_idx == 3'd6) w_state_next = S_CLEAR;
      S_CLEAR: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (level_load) w_state_next = S_IDLE;
  end

  always_ff @(posedge clock or negedge reset_state) begin
    if (!reset_state) begin
      r_x           <= '0;
      r_y           <= '0;
      r_h_dir       <= 1'b0;
      r_v_dir       <= 1'b0;
      r_idx         <= '0;
      r_alive       <= c_all;
      r_hit_mask    <= '0;
      r_distinct    <= '0;
      r_bricks_left <= c_full;
      r_v_cnt       <= '0;
      r_h_cnt       <= '0;
      r_d_cnt       <= '0;
    end else if (level_load) begin
      // Counts deliberately survive a level reload.
      r_alive       <= c_all;
      r_bricks_left <= c_full;
      r_hit_mask    <= '0;
      r_distinct    <= '0;
      r_idx         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (scan.start) begin
            r_x        <= scan.x;
            r_y        <= scan.y;
            r_h_dir    <= scan.h_dir;
            r_v_dir    <= scan.v_dir;
            r_idx      <= '0;
            r_hit_mask <= '0;
            r_distinct <= '0;
            r_v_cnt    <= '0;
            r_h_cnt    <= '0;
            r_d_cnt    <= '0;
          end
        end
        S_PROBE: begin
          r_idx <= r_idx + 3'd1;
          if (w_hit) begin
            r_hit_mask <= r_hit_mask | (c_one << w_bit_idx);
            if (w_is_v && r_v_cnt != 2'd3) r_v_cnt <= r_v_cnt + 2'd1;
            if (w_is_h && r_h_cnt != 2'd3) r_h_cnt <= r_h_cnt + 2'd1;
            if (w_is_d && r_d_cnt != 2'd3) r_d_cnt <= r_d_cnt + 2'd1;
          end
          if (w_first_hit) r_distinct <= r_distinct + 3'd1;
        end
        S_CLEAR: begin
          r_alive       <= r_alive & ~r_hit_mask;
          r_bricks_left <= r_bricks_left - 6'(r_distinct);
        end
        default: ;
      endcase
    end
  end

  assign scan.busy        = (r_state != S_IDLE);
  assign scan.done        = (r_state == S_CLEAR);
  assign scan.v_col_count = r_v_cnt;
  assign scan.h_col_count = r_h_cnt;
  assign scan.d_col_count = r_d_cnt;
  assign bricks_left      = r_bricks_left;
  assign all_cleared      = (r_bricks_left == 6'd0);

endmodule
`default_nettype wire

// File: tb/tb_brick_collision_scan.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_brick_collision_scan                                      |
// | Description : Directed self-checking bench for brick_collision_scan.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_brick_collision_scan;

  logic       clock = 1'b0;
  logic       reset_state;
  logic       level_load;
  logic [5:0] bricks_left;
  logic       all_cleared;
  logic [3:0] rd_col;
  logic [2:0] rd_row;
  logic       rd_alive;

  int          total = 0;
  int          bad   = 0;
  int          done_cyc;
  int          done_cnt;
  logic [12:0] busy_tr;
  logic        pv;
  int          n_alive;
  int          exp_left;

  always #5 clock = ~clock;

  brick_collision_scan_if bus ();

  brick_collision_scan dut (
    .clock       (clock),
    .reset_state (reset_state),
    .scan        (bus),
    .level_load  (level_load),
    .bricks_left (bricks_left),
    .all_cleared (all_cleared),
    .rd_col      (rd_col),
    .rd_row      (rd_row),
    .rd_alive    (rd_alive)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_state = 1'b0;
    bus.start   = 1'b0;
    level_load  = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_state = 1'b1;
  endtask

  task automatic peek(input logic [2:0] r, input logic [3:0] c, output logic v);
    rd_row = r;
    rd_col = c;
    #1;
    v = rd_alive;
  endtask

  task automatic count_alive(output int n);
    logic v;
    n = 0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 10; c++) begin
        peek(3'(r), 4'(c), v);
        if (v === 1'b1) n++;
      end
    sync();
  endtask

  // Cycle 0 is the start cycle; restart/abort/reset happen in the named cycle.
  task automatic run_scan(input logic [7:0] sx, input logic [6:0] sy, input logic sh,
                          input logic sv, input int restart_at, input int abort_at,
                          input int rst_at);
    bus.x = sx; bus.y = sy; bus.h_dir = sh; bus.v_dir = sv;
    bus.start = 1'b1;
    done_cyc = -1; done_cnt = 0; busy_tr = '0;
    #1;
    busy_tr[0] = bus.busy;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clock);
      #1;
      bus.start   = (c == restart_at);
      level_load  = (c == abort_at);
      reset_state = !(c == rst_at);
      #1;
      busy_tr[c] = bus.busy;
      if (bus.done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    sync();
  endtask

  function automatic logic [5:0] counts();
    return {bus.v_col_count, bus.h_col_count, bus.d_col_count};
  endfunction

  initial begin
    bus.start = 1'b0; bus.x = '0; bus.y = '0; bus.h_dir = 1'b0; bus.v_dir = 1'b0;
    rd_col = '0; rd_row = '0;
    apply_reset();

    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_counts", 32'(counts()), 0);
    check("rst_left", 32'(bricks_left), 50);
    check("rst_cleared", 32'(all_cleared), 0);
    peek(3'd0, 4'd0, pv);  check("rst_alive_00", 32'(pv), 1);
    peek(3'd5, 4'd0, pv);  check("rd_row_oob", 32'(pv), 0);
    peek(3'd0, 4'd10, pv); check("rd_col_oob", 32'(pv), 0);
    sync();

    // Ball just below the field moving up-left: V probes and D hit brick (4,1).
    run_scan(8'd20, 7'd36, 1'b0, 1'b0, 0, 0, 0);
    check("t1_done_cyc", 32'(done_cyc), 8);
    check("t1_done_cnt", 32'(done_cnt), 1);
    check("t1_busy", 32'(busy_tr), 32'h1FE);
    check("t1_counts", 32'(counts()), 32'(6'b11_00_01));
    check("t1_left", 32'(bricks_left), 49);
    peek(3'd4, 4'd1, pv); check("t1_alive_41", 32'(pv), 0);
    peek(3'd4, 4'd2, pv); check("t1_alive_42", 32'(pv), 1);
    sync();

    run_scan(8'd0, 7'd50, 1'b0, 1'b1, 0, 0, 0);
    check("t2_done_cyc", 32'(done_cyc), 8);
    check("t2_counts", 32'(counts()), 0);
    check("t2_left", 32'(bricks_left), 49);

    run_scan(8'd20, 7'd36, 1'b0, 1'b0, 0, 0, 0);
    check("t4_rep_counts", 32'(counts()), 0);
    check("t4_rep_left", 32'(bricks_left), 49);

    // Abort during probe 3: V hits already counted on brick (4,4) are kept.
    run_scan(8'd64, 7'd36, 1'b0, 1'b0, 0, 4, 0);
    check("t5_done_cnt", 32'(done_cnt), 0);
    check("t5_busy", 32'(busy_tr), 32'h01E);
    check("t5_left", 32'(bricks_left), 50);
    check("t5_counts", 32'(counts()), 32'(6'b11_00_00));
    count_alive(n_alive);
    check("t5_alive_all", 32'(n_alive), 50);

    apply_reset();
    run_scan(8'd30, 7'd36, 1'b1, 1'b0, 4, 0, 0);
    check("t3_done_cyc", 32'(done_cyc), 8);
    check("t6_done_cnt", 32'(done_cnt), 1);
    check("t6_busy", 32'(busy_tr), 32'h1FE);
    check("t3_counts", 32'(counts()), 32'(6'b11_00_01));
    check("t3_left", 32'(bricks_left), 48);
    peek(3'd4, 4'd1, pv); check("t3_alive_41", 32'(pv), 0);
    peek(3'd4, 4'd2, pv); check("t3_alive_42", 32'(pv), 0);
    peek(3'd4, 4'd3, pv); check("t3_alive_43", 32'(pv), 1);
    sync();

    run_scan(8'd64, 7'd36, 1'b0, 1'b0, 0, 0, 5);
    check("t6_rst_busy", 32'(busy_tr), 32'h01E);
    check("t6_rst_done_cnt", 32'(done_cnt), 0);
    check("t6_rst_left", 32'(bricks_left), 50);
    check("t6_rst_counts", 32'(counts()), 0);
    count_alive(n_alive);
    check("t6_rst_alive", 32'(n_alive), 50);

    // Sweep: ball inside row r at col c moving up-left clears (r,c) and (r,c-1).
    exp_left = 50;
    for (int r = 0; r < 5; r++)
      for (int k = 0; k < 5; k++) begin
        run_scan(8'(16 * (9 - 2 * k)), 7'(17 + 4 * r), 1'b0, 1'b0, 0, 0, 0);
        exp_left -= 2;
        check($sformatf("sweep_counts_r%0d_k%0d", r, k), 32'(counts()), 32'(6'b11_11_01));
        check($sformatf("sweep_left_r%0d_k%0d", r, k), 32'(bricks_left), 32'(exp_left));
      end
    check("sweep_cleared", 32'(all_cleared), 1);

    run_scan(8'd20, 7'd36, 1'b0, 1'b0, 0, 0, 0);
    check("empty_done_cyc", 32'(done_cyc), 8);
    check("empty_counts", 32'(counts()), 0);
    check("empty_left", 32'(bricks_left), 0);
    check("empty_cleared", 32'(all_cleared), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
